// File: rtl/unshifter8_seq_if.sv
// Request/response bundle for unshifter8_seq.
//   in_valid/in_ready   : request handshake (master drives valid)
//   shiftType, amt, num : forward op code, forward amount, shifted value
//   out_valid/out_ready : result handshake (slave drives valid)
//   out                 : restored value, stable while out_valid is high
//   busy                : slave is working on or holding a request
interface unshifter8_seq_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned AW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       shiftType;
  logic [AW-1:0]    amt;
  logic [WIDTH-1:0] num;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             busy;

  modport master (
    output in_valid, shiftType, amt, num, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, shiftType, amt, num, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/unshifter8_seq.sv
// Sequential inverse of the 8-bit combinational shifter. Reconstructs the
// pre-shift operand by applying the opposite shift one bit per clock.
// Bits lost by a forward logical/arithmetic shift come back as zeros.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : unshifter8_seq_if slave (request in, result out, busy)
module unshifter8_seq #(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  unshifter8_seq_if.slave  bus
);
  localparam int unsigned AW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [WIDTH-1:0] r_data, w_data_next, w_step;
  logic [AW-1:0]    r_cnt, w_cnt_next;
  logic [2:0]       r_type, w_type_next;

  // One inverse step of the latched forward operation.
  always_comb begin
    w_step = '0;
    case (r_type)
      3'b000, 3'b010: w_step = {r_data[WIDTH-2:0], 1'b0};
      3'b001, 3'b011: w_step = {1'b0, r_data[WIDTH-1:1]};
      3'b100:         w_step = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
      3'b101:         w_step = {r_data[0], r_data[WIDTH-1:1]};
      default:        w_step = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_data  <= '0;
      r_cnt   <= '0;
      r_type  <= '0;
    end else begin
      r_state <= w_state_next;
      r_data  <= w_data_next;
      r_cnt   <= w_cnt_next;
      r_type  <= w_type_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_data_next   = r_data;
    w_cnt_next    = r_cnt;
    w_type_next   = r_type;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_state)
      StIdle: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_type_next = bus.shiftType;
          w_cnt_next  = bus.amt;
          if (bus.shiftType[2:1] == 2'b11) begin
            // Codes 11x have no inverse: result is zero immediately.
            w_data_next  = '0;
            w_state_next = StDone;
          end else begin
            w_data_next  = bus.num;
            w_state_next = (bus.amt == '0) ? StDone : StShift;
          end
        end
      end
      StShift: begin
        w_data_next = w_step;
        w_cnt_next  = r_cnt - 1'b1;
        // Exit on count 1 so the counter never wraps.
        if (r_cnt == AW'(1)) w_state_next = StDone;
      end
      StDone: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign bus.out  = r_data;
  assign bus.busy = (r_state != StIdle);
endmodule

// File: tb/tb_unshifter8_seq.sv
module tb_unshifter8_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] exp_q[$];

  unshifter8_seq_if #(.WIDTH(8)) bus ();
  unshifter8_seq #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference: undo the forward shift as a whole amount with plain arithmetic.
  function automatic logic [7:0] ref_model(input logic [2:0] c, input int k,
                                           input logic [7:0] n);
    int v;
    v = int'(n);
    case (c)
      3'd0, 3'd2: v = (v << k) & 255;
      3'd1, 3'd3: v = v >> k;
      3'd4:       v = ((v << k) | (v >> (8 - k))) & 255;
      3'd5:       v = ((v >> k) | (v << (8 - k))) & 255;
      default:    v = 0;
    endcase
    return v[7:0];
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: compares every completed result handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got 0x%0h, expected no result", bus.out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.out !== e) begin
          n_fail++;
          $display("FAIL result: got 0x%0h, expected 0x%0h", bus.out, e);
        end
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!bus.in_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check("in_ready_timeout", int'(bus.in_ready), 1);
  endtask

  // One full transaction; bp = cycles of out_ready low once the result is valid.
  task automatic do_req(input logic [2:0] c, input logic [2:0] a, input logic [7:0] n,
                        input int bp);
    int lat;
    int exp_lat;
    logic [7:0] held;
    wait_ready();
    exp_lat = (a == 3'd0 || c[2:1] == 2'b11) ? 0 : int'(a);
    bus.shiftType = c;
    bus.amt       = a;
    bus.num       = n;
    bus.in_valid  = 1'b1;
    bus.out_ready = (bp == 0);
    exp_q.push_back(ref_model(c, int'(a), n));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.num      = ~n;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      check("busy_during_op", int'(bus.busy), 1);
      @(posedge clk); #1; lat++;
    end
    check("latency", lat, exp_lat);
    check("in_ready_in_done", int'(bus.in_ready), 0);
    if (bp > 0) begin
      held = bus.out;
      for (int i = 0; i < bp; i++) begin
        // Stray request while busy must be ignored.
        bus.in_valid  = (i == 1);
        bus.shiftType = 3'd4;
        bus.amt       = 3'd1;
        @(posedge clk); #1;
        check("bp_out_valid", int'(bus.out_valid), 1);
        check("bp_out_stable", int'(bus.out), int'(held));
        check("bp_in_ready", int'(bus.in_ready), 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("idle_in_ready", int'(bus.in_ready), 1);
    check("idle_out_valid", int'(bus.out_valid), 0);
    check("idle_busy", int'(bus.busy), 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.shiftType = 3'd0;
    bus.amt       = 3'd0;
    bus.num       = 8'd0;
    bus.out_ready = 1'b1;
    #12;
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_out", int'(bus.out), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_req(3'b100, 3'd3, 8'h72, 0);
    do_req(3'b001, 3'd3, 8'hA8, 0);
    do_req(3'b011, 3'd3, 8'hA8, 0);
    do_req(3'b010, 3'd2, 8'hF5, 0);
    do_req(3'b101, 3'd1, 8'h81, 0);
    do_req(3'b100, 3'd0, 8'h5A, 0);
    do_req(3'b111, 3'd5, 8'hFF, 0);
    do_req(3'b000, 3'd7, 8'h01, 0);
    do_req(3'b101, 3'd4, 8'h3C, 10);

    // Reset mid-shift: no result may come out of the aborted request.
    wait_ready();
    bus.shiftType = 3'b100;
    bus.amt       = 3'd6;
    bus.num       = 8'hC3;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", int'(bus.in_ready), 1);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_out", int'(bus.out), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_valid", int'(bus.out_valid), 0);
    end
    do_req(3'b100, 3'd6, 8'hC3, 0);

    for (int i = 0; i < 40; i++) begin
      do_req(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
